fp_int_cvt_arbiter: RTL and testbench
=====================================

Name: fp_int_cvt_arbiter

Overview:
- Shares one combinational FP-to-integer converter (FP_Int_Convert datapath) between two issue requesters.
- Round-robin arbitration, valid/ready handshakes, registered operands and results, per-response source/tag.
- Maintains the sticky NV (invalid) exception flag for the FP CSR.
- Sits between the FP issue stage and the writeback stage. The converter is instantiated outside and connected through the cvt_* ports.

Parameters:
- DATA_WIDTH, 64, operand/result width (converter width).
- TAG_WIDTH, 5, destination-register tag carried with each request.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- req0_valid / req1_valid  in  1  requester i has an operation
- req0_ready / req1_ready  out  1  requester i accepted this cycle
- req0_data / req1_data  in  DATA_WIDTH  FP operand (FP32 in bits [31:0])
- req0_fmt / req1_fmt  in  1  0=FP32, 1=FP64
- req0_out_fmt / req1_out_fmt  in  2  00=W, 01=WU, 10=L, 11=LU
- req0_tag / req1_tag  in  TAG_WIDTH  destination tag
- cvt_in_data  out  DATA_WIDTH  operand to converter
- cvt_in_fmt  out  1  to converter
- cvt_out_fmt  out  2  to converter
- cvt_out_data  in  DATA_WIDTH  converter result
- cvt_flg_NV  in  1  converter invalid flag
- rsp_valid  out  1  result available
- rsp_ready  in  1  writeback accepts
- rsp_data  out  DATA_WIDTH  integer result
- rsp_nv  out  1  NV flag of this result
- rsp_src  out  1  requester that issued it
- rsp_tag  out  TAG_WIDTH  tag of this result
- fflags_clr  in  1  clear sticky NV
- fflags_nv  out  1  sticky NV

Behaviour:
- States: IDLE, CONV, RESP. Reset (rst_n low at a clk edge):
  - state=IDLE, prio=0.
  - Operand registers (cvt_in_data, cvt_in_fmt, cvt_out_fmt, internal src/tag) = 0.
  - rsp_valid=0, rsp_data=0, rsp_nv=0, rsp_src=0, rsp_tag=0, fflags_nv=0.
  - req0_ready/req1_ready forced 0 while rst_n is low.
- can_accept = (state==IDLE) | (state==RESP & rsp_ready).
- Grant (combinational):
  - Only one valid: that requester wins.
  - Both valid: requester prio wins.
  - reqi_ready = can_accept & grant==i & rst_n.
  - req*_ready depends combinationally on rsp_ready and req*_valid. It never depends on req*_ready of the other port.
- Accept (reqi_valid & reqi_ready):
  - Operand registers load req data/fmt/out_fmt/tag and src=i.
  - prio <= ~i.
  - Next state CONV.
- IDLE:
  - No accept: stay IDLE.
  - Accept: go to CONV.
- CONV (exactly one cycle; converter settles on registered operands):
  - At the edge: rsp_data<=cvt_out_data, rsp_nv<=cvt_flg_NV, rsp_src<=src, rsp_tag<=tag, rsp_valid<=1.
  - Next state RESP.
  - No accept in CONV.
- RESP:
  - rsp_* held stable while rsp_valid & !rsp_ready.
  - On rsp_ready:
    - With accept: go to CONV (rsp_valid<=0).
    - Without accept: go to IDLE (rsp_valid<=0).
- Latency: accept at cycle N gives rsp_valid high in cycle N+2.
- Throughput: one op per 2 cycles with rsp_ready held high.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Sticky NV:
  - fflags_nv <= 1 at the CONV edge when cvt_flg_NV=1.
  - Otherwise, fflags_clr=1 clears it.
  - Set and clear in the same cycle: set wins (flag stays 1).
- prio changes only on accept. An idle requester never blocks the other.
- Reset mid-operation (CONV or RESP): the in-flight operation is dropped with no response, and the sticky flag clears.
- All arithmetic is performed by the external converter. This block performs no data transformation (pure pass/register).

Test Plan:
- Single op, bench instantiates real converter:
  - req0: data=0x40600000 (3.5f), fmt=0, out_fmt=00, tag=7.
  - Expect rsp_valid at N+2, rsp_data=0x3, rsp_nv=0, rsp_src=0, rsp_tag=7.
- Both valid continuously, 4 ops each, rsp_ready=1:
  - Grants alternate 0,1,0,1 starting with req0 after reset.
  - Each accept spaced 2 cycles; tags returned in grant order.
- Backpressure:
  - req1 FP64 -2.0 (0xC000000000000000), fmt=1, out_fmt=10.
  - rsp_ready=0 for 5 cycles: rsp_data=0xFFFFFFFFFFFFFFFE held stable, both readies 0.
  - Raise rsp_ready while req0 valid: req0_ready=1 in that same cycle.
- NV sticky:
  - 1e10f (0x501502F9), out_fmt=00: rsp_nv=1, fflags_nv=1.
  - Next op valid: fflags_nv stays 1.
  - fflags_clr asserted in the same cycle as a CONV edge with NV=1: fflags_nv stays 1.
  - fflags_clr alone: fflags_nv=0 next cycle.
- Reset mid-op:
  - Assert rst_n=0 during CONV, then during RESP.
  - Next cycle: rsp_valid=0, fflags_nv=0, prio favors req0, no stale response after release.
- Idle fairness:
  - Only req1 valid for 3 ops: all granted, each at the earliest can_accept cycle.
  - req0 then valid alongside req1: req0 granted first.

Source files
------------

// File: rtl/fp_int_cvt_arbiter.sv
// rtl/fp_int_cvt_arbiter.sv - round-robin share of one external FP-to-int converter between two requesters
module fp_int_cvt_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_fmt,
    input  logic [1:0]            req0_out_fmt,
    input  logic [TAG_WIDTH-1:0]  req0_tag,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_fmt,
    input  logic [1:0]            req1_out_fmt,
    input  logic [TAG_WIDTH-1:0]  req1_tag,
    output logic [DATA_WIDTH-1:0] cvt_in_data,
    output logic                  cvt_in_fmt,
    output logic [1:0]            cvt_out_fmt,
    input  logic [DATA_WIDTH-1:0] cvt_out_data,
    input  logic                  cvt_flg_NV,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_nv,
    output logic                  rsp_src,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    input  logic                  fflags_clr,
    output logic                  fflags_nv
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]           state;
    logic                 prio;
    logic                 src;
    logic [TAG_WIDTH-1:0] tag;
    logic                 can_accept;
    logic                 grant;
    logic                 acc0;
    logic                 acc1;
    logic                 accept;

    // A new op may enter while the previous result is being handed off.
    assign can_accept = (state == IDLE) || ((state == RESP) && rsp_ready);

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = prio;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = can_accept & ~grant & rst_n;
    assign req1_ready = can_accept & grant & rst_n;
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;
    assign accept     = acc0 | acc1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            prio        <= 1'b0;
            src         <= 1'b0;
            tag         <= '0;
            cvt_in_data <= '0;
            cvt_in_fmt  <= 1'b0;
            cvt_out_fmt <= 2'b00;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_nv      <= 1'b0;
            rsp_src     <= 1'b0;
            rsp_tag     <= '0;
            fflags_nv   <= 1'b0;
        end else begin
            if (accept) begin
                cvt_in_data <= acc1 ? req1_data : req0_data;
                cvt_in_fmt  <= acc1 ? req1_fmt : req0_fmt;
                cvt_out_fmt <= acc1 ? req1_out_fmt : req0_out_fmt;
                tag         <= acc1 ? req1_tag : req0_tag;
                src         <= acc1;
                prio        <= ~acc1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= CONV;
                    end
                end
                CONV: begin
                    rsp_data  <= cvt_out_data;
                    rsp_nv    <= cvt_flg_NV;
                    rsp_src   <= src;
                    rsp_tag   <= tag;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= accept ? CONV : IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase

            // Setting from the converter takes precedence over a software clear.
            if ((state == CONV) && cvt_flg_NV) begin
                fflags_nv <= 1'b1;
            end else if (fflags_clr) begin
                fflags_nv <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_int_cvt_arbiter.sv
// tb/tb_fp_int_cvt_arbiter.sv - randomized and directed self-checking bench for fp_int_cvt_arbiter
module tb_fp_int_cvt_arbiter;

    localparam int DW = 64;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req0_fmt;
    logic          req1_valid, req1_ready, req1_fmt;
    logic [DW-1:0] req0_data, req1_data;
    logic [1:0]    req0_out_fmt, req1_out_fmt;
    logic [TW-1:0] req0_tag, req1_tag;
    logic [DW-1:0] cvt_in_data, cvt_out_data;
    logic          cvt_in_fmt, cvt_flg_NV;
    logic [1:0]    cvt_out_fmt;
    logic          rsp_valid, rsp_ready, rsp_nv, rsp_src;
    logic [DW-1:0] rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          fflags_clr, fflags_nv;
    logic [64:0]   cvt_res;

    always #5 clk = ~clk;

    fp_int_cvt_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_fmt(req0_fmt), .req0_out_fmt(req0_out_fmt), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_fmt(req1_fmt), .req1_out_fmt(req1_out_fmt), .req1_tag(req1_tag),
        .cvt_in_data(cvt_in_data), .cvt_in_fmt(cvt_in_fmt), .cvt_out_fmt(cvt_out_fmt),
        .cvt_out_data(cvt_out_data), .cvt_flg_NV(cvt_flg_NV),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_nv(rsp_nv), .rsp_src(rsp_src), .rsp_tag(rsp_tag),
        .fflags_clr(fflags_clr), .fflags_nv(fflags_nv)
    );

    // Truncating FP-to-integer conversion with RISC-V style saturation; {nv, result}.
    function automatic logic [64:0] fp_cvt(input logic [63:0] d, input logic fmt, input logic [1:0] of);
        logic         s, special, nan, nv;
        int           e;
        logic [127:0] m, mag, pos_lim, neg_lim;
        logic [63:0]  r, pos_sat, neg_sat;
        if (!fmt) begin
            s = d[31]; e = int'(d[30:23]);
            special = (e == 255); nan = special && (d[22:0] != 0);
            m = {104'd0, e != 0, d[22:0]};
            e = e - 150;
        end else begin
            s = d[63]; e = int'(d[62:52]);
            special = (e == 2047); nan = special && (d[51:0] != 0);
            m = {75'd0, e != 0, d[51:0]};
            e = e - 1075;
        end
        if (e > 60) mag = '1;
        else if (e >= 0) mag = m << e;
        else if (e <= -128) mag = '0;
        else mag = m >> (-e);
        case (of)
            2'd0: begin pos_lim = 128'h7FFF_FFFF; neg_lim = 128'h8000_0000;
                        pos_sat = 64'h7FFF_FFFF; neg_sat = 64'hFFFF_FFFF_8000_0000; end
            2'd1: begin pos_lim = 128'hFFFF_FFFF; neg_lim = '0; pos_sat = '1; neg_sat = '0; end
            2'd2: begin pos_lim = 128'h7FFF_FFFF_FFFF_FFFF; neg_lim = 128'h8000_0000_0000_0000;
                        pos_sat = 64'h7FFF_FFFF_FFFF_FFFF; neg_sat = 64'h8000_0000_0000_0000; end
            default: begin pos_lim = 128'hFFFF_FFFF_FFFF_FFFF; neg_lim = '0; pos_sat = '1; neg_sat = '0; end
        endcase
        nv = special || (s ? (mag > neg_lim) : (mag > pos_lim));
        if (nan) r = pos_sat;
        else if (nv) r = s ? neg_sat : pos_sat;
        else begin
            r = s ? 64'(-mag) : mag[63:0];
            if (!of[1]) r = {{32{r[31]}}, r[31:0]};
        end
        return {nv, r};
    endfunction

    assign cvt_res      = fp_cvt(cvt_in_data, cvt_in_fmt, cvt_out_fmt);
    assign cvt_out_data = cvt_res[63:0];
    assign cvt_flg_NV   = cvt_res[64];

    typedef struct {
        logic [63:0] data;
        logic        nv;
        logic        src;
        logic [4:0]  tag;
    } rsp_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    rsp_t m_q[$];
    rsp_t m_op;
    logic m_conv = 1'b0;
    logic m_prio = 1'b0;
    logic m_nv = 1'b0;
    int   grant_src[$];
    int   grant_cyc[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic rsp_t make_rsp(input logic [63:0] d, input logic f, input logic [1:0] o,
                                      input logic s, input logic [4:0] t);
        rsp_t r;
        logic [64:0] c;
        c = fp_cvt(d, f, o);
        r.data = c[63:0]; r.nv = c[64]; r.src = s; r.tag = t;
        return r;
    endfunction

    // Transaction-level reference: one op in conversion, at most one pending response.
    task automatic tick();
        logic can, win, e0, e1, was_conv;
        @(negedge clk);
        cyc++;
        can = rst_n && !m_conv && (m_q.size() == 0 || rsp_ready);
        win = (req0_valid && req1_valid) ? m_prio : req1_valid;
        e0 = can && !win;
        e1 = can && win;
        check("req0_ready", 64'(req0_ready), 64'(e0));
        check("req1_ready", 64'(req1_ready), 64'(e1));
        check("rsp_valid", 64'(rsp_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("rsp_data", rsp_data, m_q[0].data);
            check("rsp_nv", 64'(rsp_nv), 64'(m_q[0].nv));
            check("rsp_src", 64'(rsp_src), 64'(m_q[0].src));
            check("rsp_tag", 64'(rsp_tag), 64'(m_q[0].tag));
        end
        check("fflags_nv", 64'(fflags_nv), 64'(m_nv));
        if (!rst_n) begin
            m_q.delete(); m_conv = 1'b0; m_prio = 1'b0; m_nv = 1'b0;
        end else begin
            was_conv = m_conv;
            if (m_q.size() != 0 && rsp_ready) void'(m_q.pop_front());
            if (was_conv && m_op.nv) m_nv = 1'b1;
            else if (fflags_clr) m_nv = 1'b0;
            if (was_conv) begin m_q.push_back(m_op); m_conv = 1'b0; end
            if (e0 && req0_valid) begin
                m_op = make_rsp(req0_data, req0_fmt, req0_out_fmt, 1'b0, req0_tag);
                m_conv = 1'b1; m_prio = 1'b1;
                grant_src.push_back(0); grant_cyc.push_back(cyc);
            end else if (e1 && req1_valid) begin
                m_op = make_rsp(req1_data, req1_fmt, req1_out_fmt, 1'b1, req1_tag);
                m_conv = 1'b1; m_prio = 1'b0;
                grant_src.push_back(1); grant_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic v, input logic [63:0] d, input logic f,
                         input logic [1:0] o, input logic [4:0] t);
        if (p == 0) begin
            req0_valid = v; req0_data = d; req0_fmt = f; req0_out_fmt = o; req0_tag = t;
        end else begin
            req1_valid = v; req1_data = d; req1_fmt = f; req1_out_fmt = o; req1_tag = t;
        end
    endtask

    function automatic logic [63:0] rand_fp(input logic f);
        logic [63:0] d;
        d = {$urandom, $urandom};
        if (!f) d[30:23] = ($urandom_range(15) == 0) ? 8'hFF : 8'($urandom_range(165, 110));
        else d[62:52] = ($urandom_range(15) == 0) ? 11'h7FF : 11'($urandom_range(1090, 1000));
        return d;
    endfunction

    task automatic drive_rand(input int p, input logic v);
        logic f;
        f = 1'($urandom);
        drive(p, v, rand_fp(f), f, 2'($urandom), 5'($urandom));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic idle_all(input int n);
        drive(0, 1'b0, '0, 1'b0, 2'b00, '0);
        drive(1, 1'b0, '0, 1'b0, 2'b00, '0);
        rsp_ready = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        int start;
        rst_n = 1'b0; rsp_ready = 1'b1; fflags_clr = 1'b0;
        drive(0, 1'b0, '0, 1'b0, 2'b00, '0);
        drive(1, 1'b0, '0, 1'b0, 2'b00, '0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_fflags", 64'(fflags_nv), 64'd0);
        do_reset();

        // Single op latency
        drive(0, 1'b1, 64'h4060_0000, 1'b0, 2'b00, 5'd7);
        tick();
        drive(0, 1'b0, '0, 1'b0, 2'b00, '0);
        check("lat_early", 64'(rsp_valid), 64'd0);
        tick();
        check("lat_valid", 64'(rsp_valid), 64'd1);
        check("single_data", rsp_data, 64'h3);
        check("single_nv", 64'(rsp_nv), 64'd0);
        check("single_src", 64'(rsp_src), 64'd0);
        check("single_tag", 64'(rsp_tag), 64'd7);
        idle_all(2);

        // Continuous contention alternates
        do_reset();
        grant_src.delete(); grant_cyc.delete();
        for (int i = 0; i < 40 && grant_src.size() < 8; i++) begin
            drive_rand(0, 1'b1);
            drive_rand(1, 1'b1);
            tick();
        end
        check("grant_count", 64'(grant_src.size()), 64'd8);
        for (int k = 0; k < grant_src.size(); k++) begin
            check("grant_order", 64'(grant_src[k]), 64'(k % 2));
            if (k > 0) check("grant_gap", 64'(grant_cyc[k] - grant_cyc[k-1]), 64'd2);
        end
        idle_all(3);

        // Backpressure
        rsp_ready = 1'b0;
        drive(1, 1'b1, 64'hC000_0000_0000_0000, 1'b1, 2'b10, 5'd3);
        tick();
        drive(1, 1'b0, '0, 1'b0, 2'b00, '0);
        drive(0, 1'b1, 64'h4060_0000, 1'b0, 2'b00, 5'd4);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFE);
            check("bp_ready0", 64'(req0_ready), 64'd0);
            check("bp_ready1", 64'(req1_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(req0_ready), 64'd1);
        tick();
        idle_all(3);

        // Sticky NV
        do_reset();
        drive(0, 1'b1, 64'h5015_02F9, 1'b0, 2'b00, 5'd9);
        tick();
        drive(0, 1'b0, '0, 1'b0, 2'b00, '0);
        tick();
        check("nv_rsp", 64'(rsp_nv), 64'd1);
        check("nv_rsp_data", rsp_data, 64'h7FFF_FFFF);
        check("nv_sticky_set", 64'(fflags_nv), 64'd1);
        drive(0, 1'b1, 64'h4060_0000, 1'b0, 2'b00, 5'd10);
        tick();
        drive(0, 1'b0, '0, 1'b0, 2'b00, '0);
        tick();
        check("nv_sticky_hold", 64'(fflags_nv), 64'd1);
        tick();
        drive(0, 1'b1, 64'h5015_02F9, 1'b0, 2'b00, 5'd11);
        tick();
        drive(0, 1'b0, '0, 1'b0, 2'b00, '0);
        fflags_clr = 1'b1;
        tick();
        check("nv_set_wins", 64'(fflags_nv), 64'd1);
        fflags_clr = 1'b0;
        tick();
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        check("nv_clear", 64'(fflags_nv), 64'd0);
        idle_all(2);

        // Reset during CONV, then during RESP
        drive(0, 1'b1, 64'h5015_02F9, 1'b0, 2'b00, 5'd12);
        tick();
        drive(0, 1'b0, '0, 1'b0, 2'b00, '0);
        rst_n = 1'b0;
        tick();
        check("rst_conv_valid", 64'(rsp_valid), 64'd0);
        check("rst_conv_nv", 64'(fflags_nv), 64'd0);
        rst_n = 1'b1;
        idle_all(3);
        rsp_ready = 1'b0;
        drive(0, 1'b1, 64'h5015_02F9, 1'b0, 2'b00, 5'd13);
        tick();
        drive(0, 1'b0, '0, 1'b0, 2'b00, '0);
        tick();
        check("rst_resp_pre_nv", 64'(fflags_nv), 64'd1);
        rst_n = 1'b0;
        tick();
        check("rst_resp_valid", 64'(rsp_valid), 64'd0);
        check("rst_resp_nv", 64'(fflags_nv), 64'd0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        drive_rand(0, 1'b1);
        drive_rand(1, 1'b1);
        #1;
        check("rst_prio", 64'(req0_ready), 64'd1);
        tick();
        idle_all(4);

        // Idle requester never blocks the other
        grant_src.delete(); grant_cyc.delete();
        start = cyc;
        for (int i = 0; i < 20 && grant_src.size() < 3; i++) begin
            drive_rand(1, 1'b1);
            tick();
        end
        check("idle_count", 64'(grant_src.size()), 64'd3);
        if (grant_cyc.size() > 0) check("idle_first", 64'(grant_cyc[0] - start), 64'd1);
        for (int k = 0; k < grant_src.size(); k++) begin
            check("idle_src", 64'(grant_src[k]), 64'd1);
            if (k > 0) check("idle_gap", 64'(grant_cyc[k] - grant_cyc[k-1]), 64'd2);
        end
        for (int i = 0; i < 10 && grant_src.size() < 4; i++) begin
            drive_rand(0, 1'b1);
            drive_rand(1, 1'b1);
            tick();
        end
        check("join_count", 64'(grant_src.size()), 64'd4);
        if (grant_src.size() > 3) check("join_first", 64'(grant_src[3]), 64'd0);
        idle_all(3);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(99) != 0);
            drive_rand(0, $urandom_range(9) < 6);
            drive_rand(1, $urandom_range(9) < 6);
            rsp_ready = ($urandom_range(9) < 7);
            fflags_clr = ($urandom_range(9) == 0);
            tick();
        end
        rst_n = 1'b1;
        fflags_clr = 1'b0;
        idle_all(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
